fn_equiv_sweep_ctrl: RTL and testbench

- Sequencer that drives the shared 4-bit input vector {w,x,y,z} into the NAND-only and NOR-only implementations of F.
- Steps through all 16 minterms, waits a settle window, samples both outputs and checks them against a golden truth table.
- Reports pass/fail, mismatch count, first failing minterm and both captured truth tables.
- Sits beside the two gate-level F implementations as the on-chip self-check for them.

---
 rtl/fn_equiv_pkg.sv | 19 +
 rtl/fn_equiv_sweep_ctrl_if.sv | 32 +++
 rtl/fn_equiv_settle_timer.sv | 38 +++
 rtl/fn_equiv_sweep_ctrl.sv | 144 ++++++++++++++
 tb/tb_fn_equiv_sweep_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/fn_equiv_pkg.sv
// Shared types and constants for the NAND/NOR functional-equivalence sweep controller.
// F is the 4-input function whose golden truth table both gate-level blocks must reproduce.
package fn_equiv_pkg;

  localparam int NUM_VEC = 16;
  localparam int VEC_W   = 4;
  localparam int CNT_W   = $clog2(NUM_VEC);
  localparam int MISS_W  = VEC_W + 1;

  localparam logic [NUM_VEC-1:0] F_GOLDEN_DEFAULT = 16'h1F55;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

endpackage

// File: rtl/fn_equiv_sweep_ctrl_if.sv
// Handshake, stimulus and result bundle between the sweep controller and its user.
// The controller side takes the slave modport; the requester/implementation side takes master.
interface fn_equiv_sweep_ctrl_if;
  import fn_equiv_pkg::*;

  logic               start;
  logic               abort;
  logic [VEC_W-1:0]   vec_o;
  logic               f_nand_i;
  logic               f_nor_i;
  logic               busy;
  logic               done;
  logic               pass;
  logic [MISS_W-1:0]  mismatch_cnt;
  logic               first_fail_valid;
  logic [VEC_W-1:0]   first_fail_idx;
  logic [NUM_VEC-1:0] tt_nand;
  logic [NUM_VEC-1:0] tt_nor;

  modport slave (
    input  start, abort, f_nand_i, f_nor_i,
    output vec_o, busy, done, pass, mismatch_cnt,
           first_fail_valid, first_fail_idx, tt_nand, tt_nor
  );

  modport master (
    output start, abort, f_nand_i, f_nor_i,
    input  vec_o, busy, done, pass, mismatch_cnt,
           first_fail_valid, first_fail_idx, tt_nand, tt_nor
  );

endinterface

// File: rtl/fn_equiv_settle_timer.sv
// Loadable down-counter that flags the last cycle of the settle window.
// expire is high while the count is 1, so the caller can move on at that edge.
module fn_equiv_settle_timer
  import fn_equiv_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expire
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == W'(1));

endmodule

// File: rtl/fn_equiv_sweep_ctrl.sv
// Drives all 16 minterms into the NAND-only and NOR-only F blocks, captures both outputs
// after a settle window and scores them against the golden truth table.
module fn_equiv_sweep_ctrl
  import fn_equiv_pkg::*;
#(
  parameter int                 SETTLE_CYCLES = 2,
  parameter logic [NUM_VEC-1:0] GOLDEN        = F_GOLDEN_DEFAULT
) (
  input logic                  clk,
  input logic                  rst_n,
  fn_equiv_sweep_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(NUM_VEC - 1);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   idx_q, idx_d;
  logic [NUM_VEC-1:0] tt_nand_q, tt_nand_d;
  logic [NUM_VEC-1:0] tt_nor_q, tt_nor_d;
  logic [MISS_W-1:0]  mismatch_q, mismatch_d;
  logic               ff_valid_q, ff_valid_d;
  logic [VEC_W-1:0]   ff_idx_q, ff_idx_d;
  logic               pass_q, pass_d;

  logic timer_load;
  logic timer_dec;
  logic timer_expire;
  logic sample_fail;

  fn_equiv_settle_timer #(
    .W(CNT_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .dec      (timer_dec),
    .expire   (timer_expire)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tt_nand_d   = tt_nand_q;
    tt_nor_d    = tt_nor_q;
    mismatch_d  = mismatch_q;
    ff_valid_d  = ff_valid_q;
    ff_idx_d    = ff_idx_q;
    pass_d      = pass_q;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    sample_fail = (bus.f_nand_i != GOLDEN[idx_q]) || (bus.f_nor_i != GOLDEN[idx_q]);

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          idx_d      = '0;
          tt_nand_d  = '0;
          tt_nor_d   = '0;
          mismatch_d = '0;
          ff_valid_d = 1'b0;
          ff_idx_d   = '0;
          pass_d     = 1'b0;
          timer_load = 1'b1;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          timer_dec = 1'b1;
          if (timer_expire) begin
            state_d = SAMPLE;
          end
        end
      end
      SAMPLE: begin
        // An abort here discards the sample so partial results stay as they were.
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          tt_nand_d[idx_q] = bus.f_nand_i;
          tt_nor_d[idx_q]  = bus.f_nor_i;
          if (sample_fail) begin
            mismatch_d = mismatch_q + MISS_W'(1);
            if (!ff_valid_q) begin
              ff_valid_d = 1'b1;
              ff_idx_d   = idx_q;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d      = idx_q + VEC_W'(1);
            timer_load = 1'b1;
            state_d    = SETTLE;
          end
        end
      end
      DONE: begin
        pass_d  = (mismatch_q == '0);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tt_nand_q  <= '0;
      tt_nor_q   <= '0;
      mismatch_q <= '0;
      ff_valid_q <= 1'b0;
      ff_idx_q   <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tt_nand_q  <= tt_nand_d;
      tt_nor_q   <= tt_nor_d;
      mismatch_q <= mismatch_d;
      ff_valid_q <= ff_valid_d;
      ff_idx_q   <= ff_idx_d;
      pass_q     <= pass_d;
    end
  end

  assign bus.vec_o            = idx_q;
  assign bus.busy             = (state_q == SETTLE) || (state_q == SAMPLE);
  assign bus.done             = (state_q == DONE);
  assign bus.pass             = pass_q;
  assign bus.mismatch_cnt     = mismatch_q;
  assign bus.first_fail_valid = ff_valid_q;
  assign bus.first_fail_idx   = ff_idx_q;
  assign bus.tt_nand          = tt_nand_q;
  assign bus.tt_nor           = tt_nor_q;

endmodule

// File: tb/tb_fn_equiv_sweep_ctrl.sv
// Directed bench for fn_equiv_sweep_ctrl: gate-level models of F feed the DUT, with
// selectable faults, and a table of sweeps plus hand-written reset/abort sequences.
module tb_fn_equiv_sweep_ctrl;

  logic clk;
  logic rst_n;
  logic [1:0] fault_mode;
  logic w, x, y, z;
  logic nand_good, nor_good;

  int checks;
  int failures;

  fn_equiv_sweep_ctrl_if bus_if ();

  fn_equiv_sweep_ctrl #(
    .SETTLE_CYCLES (2),
    .GOLDEN        (16'h1F55)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign {w, x, y, z} = bus_if.vec_o;

  // F = w'z' + wx' + y'z' built from NANDs, and its product-of-sums form from NORs.
  assign nand_good = ~&{~&{~w, ~z}, ~&{w, ~x}, ~&{~y, ~z}};
  assign nor_good  = ~|{~|{w, ~z}, ~|{~x, ~z}, ~|{~w, ~x, ~y}};

  // Fault modes: 0 healthy, 1 NOR stuck-at-0, 2 NAND inverted at minterm 13, 3 NAND stuck-at-1.
  always_comb begin
    bus_if.f_nand_i = nand_good;
    bus_if.f_nor_i  = nor_good;
    case (fault_mode)
      2'd1: bus_if.f_nor_i = 1'b0;
      2'd2: if (bus_if.vec_o == 4'd13) bus_if.f_nand_i = ~nand_good;
      2'd3: bus_if.f_nand_i = 1'b1;
      default: ;
    endcase
  end

  typedef struct {
    logic [1:0]  fault;
    logic [4:0]  mm;
    logic        ffv;
    logic [3:0]  ffi;
    logic [15:0] tt_nand;
    logic [15:0] tt_nor;
    logic        pass;
  } sweep_vec_t;

  sweep_vec_t tbl [4];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_vec(input logic [3:0] v, output bit found);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus_if.vec_o === v && bus_if.busy === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Pulses start from an IDLE negedge; returns in the cycle after done.
  task automatic apply_stimulus(output int lat, output int seq_err, output int clear_err);
    lat       = 0;
    seq_err   = 0;
    clear_err = 0;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    if (bus_if.tt_nand !== 16'h0 || bus_if.tt_nor !== 16'h0 || bus_if.mismatch_cnt !== 5'd0 ||
        bus_if.first_fail_valid !== 1'b0 || bus_if.pass !== 1'b0)
      clear_err = 1;
    for (int k = 1; k <= 120; k++) begin
      bus_if.start = (k == 10 || k == 30);
      if (bus_if.done === 1'b1) begin
        lat = k;
        break;
      end
      if (bus_if.vec_o !== 4'((k - 1) / 3) || bus_if.busy !== 1'b1) seq_err++;
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int  lat, seq_err, clear_err, done_seen;
    bit  found;

    checks     = 0;
    failures   = 0;
    fault_mode = 2'd0;
    rst_n      = 1'b0;
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;

    tbl[0] = '{fault: 2'd0, mm: 5'd0, ffv: 1'b0, ffi: 4'd0,  tt_nand: 16'h1F55, tt_nor: 16'h1F55, pass: 1'b1};
    tbl[1] = '{fault: 2'd1, mm: 5'd9, ffv: 1'b1, ffi: 4'd0,  tt_nand: 16'h1F55, tt_nor: 16'h0000, pass: 1'b0};
    tbl[2] = '{fault: 2'd2, mm: 5'd1, ffv: 1'b1, ffi: 4'd13, tt_nand: 16'h3F55, tt_nor: 16'h1F55, pass: 1'b0};
    tbl[3] = '{fault: 2'd3, mm: 5'd7, ffv: 1'b1, ffi: 4'd1,  tt_nand: 16'hFFFF, tt_nor: 16'h1F55, pass: 1'b0};

    repeat (3) @(negedge clk);
    check_output("reset_ctrl", 32'({bus_if.vec_o, bus_if.busy, bus_if.done, bus_if.pass,
                 bus_if.mismatch_cnt, bus_if.first_fail_valid, bus_if.first_fail_idx}), 32'h0);
    check_output("reset_tt_nand", 32'(bus_if.tt_nand), 32'h0);
    check_output("reset_tt_nor", 32'(bus_if.tt_nor), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the middle of a sweep.
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_vec(4'd7, found);
    check_output("wait_vec7", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("midreset_busy_vec", 32'({bus_if.busy, bus_if.vec_o}), 32'h0);
    check_output("midreset_tt", 32'({bus_if.tt_nand, bus_if.tt_nor}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) done_seen++;
    end
    check_output("midreset_no_done", 32'(done_seen), 32'd0);

    // Abort while vec_o==5 is settling.
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_vec(4'd5, found);
    check_output("wait_vec5", 32'(found), 32'd1);
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    check_output("abort_busy", 32'(bus_if.busy), 32'd0);
    check_output("abort_vec_hold", 32'(bus_if.vec_o), 32'd5);
    check_output("abort_tt_nand", 32'(bus_if.tt_nand), 32'h0015);
    check_output("abort_tt_nor", 32'(bus_if.tt_nor), 32'h0015);
    done_seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1 || bus_if.pass === 1'b1 || bus_if.vec_o !== 4'd5) done_seen++;
    end
    check_output("abort_no_done", 32'(done_seen), 32'd0);

    // start and abort together in IDLE must not begin a sweep.
    bus_if.start = 1'b1;
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus_if.busy !== 1'b0 || bus_if.vec_o !== 4'd5) done_seen++;
      @(negedge clk);
    end
    check_output("start_abort_ignored", 32'(done_seen), 32'd0);

    // Back-to-back sweeps from the table, each started the cycle after the previous done.
    for (int i = 0; i < 4; i++) begin
      fault_mode = tbl[i].fault;
      apply_stimulus(lat, seq_err, clear_err);
      check_output($sformatf("sweep%0d_clear_on_start", i), 32'(clear_err), 32'd0);
      check_output($sformatf("sweep%0d_latency", i), 32'(lat), 32'd49);
      check_output($sformatf("sweep%0d_vec_seq", i), 32'(seq_err), 32'd0);
      check_output($sformatf("sweep%0d_done_pulse", i), 32'({bus_if.done, bus_if.busy}), 32'd0);
      check_output($sformatf("sweep%0d_pass", i), 32'(bus_if.pass), 32'(tbl[i].pass));
      check_output($sformatf("sweep%0d_mismatch", i), 32'(bus_if.mismatch_cnt), 32'(tbl[i].mm));
      check_output($sformatf("sweep%0d_ff_valid", i), 32'(bus_if.first_fail_valid), 32'(tbl[i].ffv));
      check_output($sformatf("sweep%0d_ff_idx", i), 32'(bus_if.first_fail_idx), 32'(tbl[i].ffi));
      check_output($sformatf("sweep%0d_tt_nand", i), 32'(bus_if.tt_nand), 32'(tbl[i].tt_nand));
      check_output($sformatf("sweep%0d_tt_nor", i), 32'(bus_if.tt_nor), 32'(tbl[i].tt_nor));
      check_output($sformatf("sweep%0d_vec_end", i), 32'(bus_if.vec_o), 32'hF);
    end

    fault_mode = 2'd0;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.mismatch_cnt !== 5'd7) done_seen++;
    end
    check_output("idle_hold_results", 32'(done_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
